mdu_div: RTL and testbench
==========================

Name: mdu_div

Overview:
Iterative radix-2 restoring divider for MIPS DIV/DIVU. It sits in the multiply/divide path, directly upstream of the HI/LO register. It accepts operands from the execute stage and stalls the pipeline while it iterates. On completion it delivers the remainder on hi_o, the quotient on lo_o, and a 2-bit HI/LO write enable for one cycle.

Parameters:
DATA_W, 32, operand/result width in bits; iteration count equals DATA_W.

Ports:
clk  input  1  system clock; all state updates on rising edge.
resetn  input  1  reset; asynchronous, active-high (resetn=1 resets).
start_i  input  1  start request from execute stage; sampled only in IDLE.
signed_i  input  1  1 = DIV (two's complement), 0 = DIVU.
dividend_i  input  DATA_W  rs operand.
divisor_i  input  DATA_W  rt operand.
cancel_i  input  1  pipeline flush/exception; aborts any operation in progress.
stall_o  output  1  pipeline stall request.
busy_o  output  1  state != IDLE.
result_valid_o  output  1  one-cycle pulse: result present.
hilo_we_o  output  2  {HI we, LO we}; 2'b11 when result_valid_o is high, else 2'b00.
hi_o  output  DATA_W  remainder.
lo_o  output  DATA_W  quotient.

Behaviour:
- Reset (async, any state): state=IDLE, counter=0, all working registers 0. Outputs: stall_o=0, busy_o=0, result_valid_o=0, hilo_we_o=2'b00, hi_o=0, lo_o=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - start_i=1 and cancel_i=0: latch |dividend| and |divisor| (absolute value only when signed_i=1), the sign of the quotient (dividend MSB XOR divisor MSB, signed only), and the sign of the remainder (dividend MSB, signed only).
  - Clear the partial remainder and counter, then go to BUSY.
- BUSY:
  - One quotient bit per cycle: shift {rem, quot} left by 1, trial-subtract the divisor magnitude from the upper DATA_W+1 bits.
  - If non-negative: keep the difference and set quot LSB=1. Otherwise restore and set LSB=0.
  - Counter increments each cycle. After DATA_W iterations go to DONE.
- DONE:
  - Apply sign correction: negate the quotient if its sign is negative; negate the remainder if the dividend was negative.
  - Drive hi_o/lo_o, result_valid_o=1, hilo_we_o=2'b11 for exactly one cycle, then return to IDLE.
  - hi_o/lo_o hold their last value afterwards.
- Latency: start_i high in cycle 0 -> BUSY in cycles 1..DATA_W -> result_valid_o in cycle DATA_W+1 (cycle 33 for DATA_W=32).
- Back-to-back: a new start_i is accepted in the IDLE cycle following DONE.
- stall_o = (IDLE & start_i & !cancel_i) | BUSY. stall_o is low in DONE, so the instruction advances with the result.
- start_i while BUSY/DONE: ignored; operands are not re-latched.
- cancel_i high in any state: next edge goes to IDLE, with no result_valid_o and no hilo_we_o. cancel_i wins over start_i in the same cycle and over DONE (that cycle's hilo_we_o is forced to 2'b00).
- Divide by zero (divisor=0): iterate normally. Result is quotient=all ones and remainder=dividend, with no sign correction applied in either mode.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0 (magnitude arithmetic wraps naturally).
- All arithmetic is on DATA_W+1 bits internally. Negation is two's complement modulo 2^DATA_W.

Optional Feature:
MDU_DIV_EARLY_EXIT_EN
- Defined: in IDLE on accept, if divisor magnitude > dividend magnitude (divisor nonzero), skip BUSY and go directly to DONE.
  - Result: quotient=0, remainder=original dividend_i.
  - result_valid_o in cycle 1; stall_o is high in cycle 0 only.
- Undefined: every operation takes the full DATA_W iterations; results are identical in both builds.

Test Plan:
- DIVU 7/2: start cycle 0 -> cycle 33 result_valid_o=1, hilo_we_o=2'b11, lo_o=3, hi_o=1; stall_o high cycles 0..32.
- DIV -7/2 (0xFFFFFFF9, 2) -> lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. DIV 7/-2 -> lo_o=0xFFFFFFFD, hi_o=1.
- DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0. DIVU 0x1234/0 -> lo_o=0xFFFFFFFF, hi_o=0x1234.
- DIVU 100/7, cancel_i pulsed at cycle 10 -> IDLE at cycle 11, busy_o=0, no result_valid_o. New DIVU 9/3 then completes with lo_o=3, hi_o=0.
- Assert resetn mid-BUSY (asynchronously, between edges) -> all outputs 0 immediately. start_i held high during BUSY is ignored; the result matches the original operands.
- MDU_DIV_EARLY_EXIT_EN defined: DIVU 5/9 -> result_valid_o in cycle 1, lo_o=0, hi_o=5. Undefined: same values at cycle 33.

Source files
------------

// File: rtl/mdu_div.sv
// ----------------------------------------------------------------------------
// mdu_div : iterative radix-2 restoring divider for MIPS DIV / DIVU.
//
// Sits in front of the HI/LO register. It takes rs/rt from execute, stalls the
// pipeline while it iterates (one quotient bit per cycle), then presents the
// remainder on hi_o and the quotient on lo_o with a one-cycle HI/LO write
// enable. Division runs on operand magnitudes and is sign-corrected at the end.
//
// Optional build macro:
//   MDU_DIV_EARLY_EXIT_EN - when defined, an operation whose divisor magnitude
//   exceeds the dividend magnitude (divisor nonzero) skips the iteration phase
//   and completes one cycle after acceptance with quotient 0 and remainder equal
//   to the dividend. Results are identical with or without the macro.
// ----------------------------------------------------------------------------
module mdu_div #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start_i,
   input  logic              signed_i,
   input  logic [DATA_W-1:0] dividend_i,
   input  logic [DATA_W-1:0] divisor_i,
   input  logic              cancel_i,
   output logic              stall_o,
   output logic              busy_o,
   output logic              result_valid_o,
   output logic [1:0]        hilo_we_o,
   output logic [DATA_W-1:0] hi_o,
   output logic [DATA_W-1:0] lo_o
);

   // The counter has to be able to hold DATA_W - 1 (the last iteration index).
   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_next;

   // Working registers
   logic [CNT_W-1:0]  count;
   logic [DATA_W-1:0] divisor_mag;    // |divisor| for the whole operation
   logic [DATA_W-1:0] rem;            // partial remainder
   logic [DATA_W-1:0] quot;           // dividend bits shift out, quotient bits shift in
   logic [DATA_W-1:0] dividend_orig;  // untouched dividend for the divide-by-zero result
   logic              divisor_zero;
   logic              quot_neg;
   logic              rem_neg;

   // Result holding registers driving hi_o / lo_o
   logic [DATA_W-1:0] hi_q;
   logic [DATA_W-1:0] lo_q;

   // Operand conditioning and per-iteration datapath
   logic [DATA_W-1:0] dividend_mag_in;
   logic [DATA_W-1:0] divisor_mag_in;
   logic              accept;
   logic              early_exit;
   logic              last_iter;
   logic [DATA_W:0]   shifted;
   logic [DATA_W:0]   diff;
   logic [DATA_W-1:0] rem_step;
   logic [DATA_W-1:0] quot_step;
   logic [DATA_W-1:0] rem_fix;
   logic [DATA_W-1:0] quot_fix;

   // Absolute values are taken only for DIV; -0x80000000 wraps to 0x80000000,
   // which is the correct unsigned magnitude 2^(DATA_W-1).
   assign dividend_mag_in = (signed_i && dividend_i[DATA_W-1]) ? -dividend_i : dividend_i;
   assign divisor_mag_in  = (signed_i && divisor_i[DATA_W-1])  ? -divisor_i  : divisor_i;

   assign accept    = (state == ST_IDLE) && start_i && !cancel_i;
   assign last_iter = (state == ST_BUSY) && (count == CNT_W'(DATA_W - 1));

`ifdef MDU_DIV_EARLY_EXIT_EN
   assign early_exit = (divisor_mag_in != '0) && (divisor_mag_in > dividend_mag_in);
`else
   assign early_exit = 1'b0;
`endif

   // One restoring step: shift the next dividend bit into the remainder, try
   // to subtract the divisor on DATA_W+1 bits, keep the difference if it did
   // not go negative. A restore can only happen when the shifted value is
   // below the divisor, so its top bit is zero and dropping it is lossless.
   assign shifted   = {rem, quot[DATA_W-1]};
   assign diff      = shifted - {1'b0, divisor_mag};
   assign rem_step  = diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
   assign quot_step = {quot[DATA_W-2:0], ~diff[DATA_W]};

   // Sign correction is folded into the final iteration so hi_o/lo_o come
   // straight from flops during DONE. Divide-by-zero skips correction: the
   // quotient is naturally all ones and the remainder is the raw dividend.
   assign quot_fix = divisor_zero ? quot_step     : (quot_neg ? -quot_step : quot_step);
   assign rem_fix  = divisor_zero ? dividend_orig : (rem_neg  ? -rem_step  : rem_step);

   // State register
   // NOTE: every clocked block uses non-blocking assignments so all flops see
   // pre-edge values and simulation order cannot change the result.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state and control outputs; cancel overrides everything
   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave one unassigned and infer a latch.
   always_comb begin
      state_next     = state;
      stall_o        = 1'b0;
      result_valid_o = 1'b0;
      case (state)
         ST_IDLE: begin
            stall_o = start_i && !cancel_i;
            if (accept) begin
               state_next = early_exit ? ST_DONE : ST_BUSY;
            end
         end
         ST_BUSY: begin
            stall_o = 1'b1;
            if (last_iter) begin
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            // Stall drops here so the instruction advances with the result.
            result_valid_o = 1'b1;
            state_next     = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (cancel_i) begin
         state_next     = ST_IDLE;
         result_valid_o = 1'b0;
      end
   end

   assign busy_o    = (state != ST_IDLE);
   assign hilo_we_o = {2{result_valid_o}};
   assign hi_o      = hi_q;
   assign lo_o      = lo_q;

   // Operand capture, iteration and result registers
   // NOTE: the working registers are reset as well as the state so that a
   // reset leaves hi_o/lo_o and every internal value at a known zero.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn) begin
         count         <= '0;
         divisor_mag   <= '0;
         rem           <= '0;
         quot          <= '0;
         dividend_orig <= '0;
         divisor_zero  <= 1'b0;
         quot_neg      <= 1'b0;
         rem_neg       <= 1'b0;
         hi_q          <= '0;
         lo_q          <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  count         <= '0;
                  rem           <= '0;
                  quot          <= dividend_mag_in;
                  divisor_mag   <= divisor_mag_in;
                  dividend_orig <= dividend_i;
                  divisor_zero  <= (divisor_i == '0);
                  quot_neg      <= signed_i && (dividend_i[DATA_W-1] ^ divisor_i[DATA_W-1]);
                  rem_neg       <= signed_i && dividend_i[DATA_W-1];
                  if (early_exit) begin
                     hi_q <= dividend_i;
                     lo_q <= '0;
                  end
               end
            end
            ST_BUSY: begin
               rem   <= rem_step;
               quot  <= quot_step;
               count <= count + CNT_W'(1);
               if (last_iter && !cancel_i) begin
                  hi_q <= rem_fix;
                  lo_q <= quot_fix;
               end
            end
            default: begin
               // DONE: results already registered; nothing to update.
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_div.sv
// ----------------------------------------------------------------------------
// tb_mdu_div : directed self-checking bench for mdu_div (DATA_W = 32).
// Inputs are driven just after the falling edge and outputs sampled 1 ns
// later, well away from the rising edge. Cycle 0 is the cycle in which
// start_i is high while the divider is idle.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mdu_div;

   logic        clk;
   logic        resetn;
   logic        start_i;
   logic        signed_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic        cancel_i;
   logic        stall_o;
   logic        busy_o;
   logic        result_valid_o;
   logic [1:0]  hilo_we_o;
   logic [31:0] hi_o;
   logic [31:0] lo_o;

   int checks = 0;
   int errors = 0;

`ifdef MDU_DIV_EARLY_EXIT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 33;
`endif

   mdu_div #(.DATA_W(32)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .start_i        (start_i),
      .signed_i       (signed_i),
      .dividend_i     (dividend_i),
      .divisor_i      (divisor_i),
      .cancel_i       (cancel_i),
      .stall_o        (stall_o),
      .busy_o         (busy_o),
      .result_valid_o (result_valid_o),
      .hilo_we_o      (hilo_we_o),
      .hi_o           (hi_o),
      .lo_o           (lo_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Issue one operation and follow it to completion (bounded). lat = -1 if
   // no result appears. stall_ok: stall high in cycle 0 and every cycle before
   // the result. we_ok: write enable 11, stall low, busy high in DONE.
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output logic [31:0] hi, output logic [31:0] lo,
                          output logic we_ok, output logic stall_ok);
      lat      = -1;
      hi       = '0;
      lo       = '0;
      we_ok    = 1'b0;
      stall_ok = 1'b1;
      @(negedge clk);
      signed_i   = sgn;
      dividend_i = a;
      divisor_i  = b;
      start_i    = 1'b1;
      #1;
      if (stall_o !== 1'b1) stall_ok = 1'b0;
      @(negedge clk);
      start_i = 1'b0;
      for (int c = 1; c <= 100 && lat < 0; c++) begin
         #1;
         if (result_valid_o === 1'b1) begin
            lat   = c;
            hi    = hi_o;
            lo    = lo_o;
            we_ok = (hilo_we_o === 2'b11) && (stall_o === 1'b0) && (busy_o === 1'b1);
         end else begin
            if (stall_o !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_reset();
      resetn     = 1'b1;
      start_i    = 1'b0;
      signed_i   = 1'b0;
      dividend_i = '0;
      divisor_i  = '0;
      cancel_i   = 1'b0;
      #3;
      checks++;
      if ({stall_o, busy_o, result_valid_o, hilo_we_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_ctrl: got %b expected 00000", {stall_o, busy_o, result_valid_o, hilo_we_o});
      end
      checks++;
      if ({hi_o, lo_o} !== 64'h0) begin
         errors++;
         $display("FAIL reset_hilo: got hi=%h lo=%h expected 0/0", hi_o, lo_o);
      end
      repeat (2) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      #1;
      checks++;
      if ({busy_o, result_valid_o, lo_o} !== 34'h0) begin
         errors++;
         $display("FAIL post_reset_idle: got busy=%b valid=%b lo=%h expected 0/0/0", busy_o, result_valid_o, lo_o);
      end
   endtask

   task automatic test_divu_basic();
      int lat; logic [31:0] hi, lo; logic we_ok, stall_ok;
      run_div(1'b0, 32'd7, 32'd2, lat, hi, lo, we_ok, stall_ok);
      checks++;
      if (lat !== 33) begin errors++; $display("FAIL divu_7_2 latency: got %0d expected 33", lat); end
      checks++;
      if (lo !== 32'd3 || hi !== 32'd1) begin
         errors++; $display("FAIL divu_7_2 result: got lo=%h hi=%h expected 3/1", lo, hi);
      end
      checks++;
      if (!we_ok) begin errors++; $display("FAIL divu_7_2 done_ctrl: got we/stall/busy wrong expected 11/0/1"); end
      checks++;
      if (!stall_ok) begin errors++; $display("FAIL divu_7_2 stall: got a low stall in cycles 0..32 expected high"); end
      // One cycle after DONE: idle, no enable, results held.
      @(negedge clk);
      #1;
      checks++;
      if (result_valid_o !== 1'b0 || hilo_we_o !== 2'b00 || busy_o !== 1'b0) begin
         errors++; $display("FAIL divu_7_2 pulse: got valid=%b we=%b busy=%b expected 0/00/0", result_valid_o, hilo_we_o, busy_o);
      end
      checks++;
      if (lo_o !== 32'd3 || hi_o !== 32'd1) begin
         errors++; $display("FAIL divu_7_2 hold: got lo=%h hi=%h expected 3/1", lo_o, hi_o);
      end
   endtask

   // The second operation is issued in the IDLE cycle right after DONE.
   task automatic test_back_to_back();
      int lat; logic [31:0] hi, lo; logic we_ok, stall_ok;
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, hi, lo, we_ok, stall_ok);
      checks++;
      if (lat !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL div_m7_2: got lat=%0d lo=%h hi=%h expected 33/fffffffd/ffffffff", lat, lo, hi);
      end
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, hi, lo, we_ok, stall_ok);
      checks++;
      if (lat !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
         errors++; $display("FAIL div_7_m2: got lat=%0d lo=%h hi=%h expected 33/fffffffd/1", lat, lo, hi);
      end
      checks++;
      if (!we_ok || !stall_ok) begin errors++; $display("FAIL div_7_m2 ctrl: got we_ok=%b stall_ok=%b expected 1/1", we_ok, stall_ok); end
   endtask

   task automatic test_corners();
      int lat; logic [31:0] hi, lo; logic we_ok, stall_ok;
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, hi, lo, we_ok, stall_ok);
      checks++;
      if (lat !== 33 || lo !== 32'h8000_0000 || hi !== 32'h0) begin
         errors++; $display("FAIL div_overflow: got lat=%0d lo=%h hi=%h expected 33/80000000/0", lat, lo, hi);
      end
      run_div(1'b0, 32'h1234, 32'h0, lat, hi, lo, we_ok, stall_ok);
      checks++;
      if (lat !== 33 || lo !== 32'hFFFF_FFFF || hi !== 32'h1234) begin
         errors++; $display("FAIL divu_by_zero: got lat=%0d lo=%h hi=%h expected 33/ffffffff/1234", lat, lo, hi);
      end
      run_div(1'b0, 32'hFFFF_FFFF, 32'h10, lat, hi, lo, we_ok, stall_ok);
      checks++;
      if (lo !== 32'h0FFF_FFFF || hi !== 32'hF) begin
         errors++; $display("FAIL divu_max_16: got lo=%h hi=%h expected 0fffffff/f", lo, hi);
      end
   endtask

   task automatic test_cancel();
      int lat; logic [31:0] hi, lo; logic we_ok, stall_ok;
      logic seen_valid;
      @(negedge clk);
      signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7; start_i = 1'b1;
      @(negedge clk);                 // cycle 1
      start_i = 1'b0;
      repeat (9) @(negedge clk);      // cycle 10
      cancel_i = 1'b1;
      @(negedge clk);                 // cycle 11
      cancel_i = 1'b0;
      #1;
      checks++;
      if (busy_o !== 1'b0 || stall_o !== 1'b0 || result_valid_o !== 1'b0) begin
         errors++; $display("FAIL cancel_idle: got busy=%b stall=%b valid=%b expected 0/0/0", busy_o, stall_o, result_valid_o);
      end
      seen_valid = 1'b0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         #1;
         if (result_valid_o !== 1'b0 || hilo_we_o !== 2'b00) seen_valid = 1'b1;
      end
      checks++;
      if (seen_valid !== 1'b0) begin errors++; $display("FAIL cancel_no_result: got a result pulse expected none"); end
      run_div(1'b0, 32'd9, 32'd3, lat, hi, lo, we_ok, stall_ok);
      checks++;
      if (lat !== 33 || lo !== 32'd3 || hi !== 32'd0) begin
         errors++; $display("FAIL after_cancel_9_3: got lat=%0d lo=%h hi=%h expected 33/3/0", lat, lo, hi);
      end
   endtask

   // start_i stays high through BUSY and DONE with different operands.
   task automatic test_start_ignored();
      int lat;
      logic [31:0] hi, lo;
      lat = -1; hi = '0; lo = '0;
      @(negedge clk);
      signed_i = 1'b0; dividend_i = 32'd200; divisor_i = 32'd7; start_i = 1'b1;
      @(negedge clk);
      dividend_i = 32'd1000; divisor_i = 32'd3;
      for (int c = 1; c <= 100 && lat < 0; c++) begin
         #1;
         if (result_valid_o === 1'b1) begin
            lat = c; hi = hi_o; lo = lo_o;
            start_i = 1'b0;
         end else begin
            @(negedge clk);
         end
      end
      start_i = 1'b0;
      checks++;
      if (lat !== 33 || lo !== 32'd28 || hi !== 32'd4) begin
         errors++; $display("FAIL start_ignored: got lat=%0d lo=%h hi=%h expected 33/1c/4", lat, lo, hi);
      end
      @(negedge clk);
      #1;
      checks++;
      if (busy_o !== 1'b0) begin errors++; $display("FAIL start_ignored_idle: got busy=%b expected 0", busy_o); end
   endtask

   task automatic test_async_reset();
      int lat; logic [31:0] hi, lo; logic we_ok, stall_ok;
      @(negedge clk);
      signed_i = 1'b0; dividend_i = 32'd50; divisor_i = 32'd6; start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2;
      resetn = 1'b1;
      #1;
      checks++;
      if ({stall_o, busy_o, result_valid_o, hilo_we_o} !== 5'b0) begin
         errors++; $display("FAIL async_reset_ctrl: got %b expected 00000", {stall_o, busy_o, result_valid_o, hilo_we_o});
      end
      checks++;
      if ({hi_o, lo_o} !== 64'h0) begin
         errors++; $display("FAIL async_reset_hilo: got hi=%h lo=%h expected 0/0", hi_o, lo_o);
      end
      @(negedge clk);
      resetn = 1'b0;
      run_div(1'b0, 32'd50, 32'd6, lat, hi, lo, we_ok, stall_ok);
      checks++;
      if (lat !== 33 || lo !== 32'd8 || hi !== 32'd2) begin
         errors++; $display("FAIL after_reset_50_6: got lat=%0d lo=%h hi=%h expected 33/8/2", lat, lo, hi);
      end
   endtask

   task automatic test_early_exit();
      int lat; logic [31:0] hi, lo; logic we_ok, stall_ok;
      run_div(1'b0, 32'd5, 32'd9, lat, hi, lo, we_ok, stall_ok);
      checks++;
      if (lat !== EARLY_LAT) begin errors++; $display("FAIL small_over_large latency: got %0d expected %0d", lat, EARLY_LAT); end
      checks++;
      if (lo !== 32'd0 || hi !== 32'd5 || !we_ok || !stall_ok) begin
         errors++; $display("FAIL small_over_large: got lo=%h hi=%h we_ok=%b stall_ok=%b expected 0/5/1/1", lo, hi, we_ok, stall_ok);
      end
      run_div(1'b1, 32'hFFFF_FFFB, 32'd9, lat, hi, lo, we_ok, stall_ok);
      checks++;
      if (lat !== EARLY_LAT || lo !== 32'd0 || hi !== 32'hFFFF_FFFB) begin
         errors++; $display("FAIL div_m5_9: got lat=%0d lo=%h hi=%h expected %0d/0/fffffffb", lat, lo, hi, EARLY_LAT);
      end
   endtask

   initial begin
      test_reset();
      test_divu_basic();
      test_back_to_back();
      test_corners();
      test_cancel();
      test_start_ignored();
      test_async_reset();
      test_early_exit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test expected completion before 200000 ns");
      $fatal(1, "watchdog expired");
   end

endmodule
